// File: rtl/multiboot_icap_seq.sv
// Spartan-6 multiboot controller: ZX-UNO register bus front end plus ICAP IPROG sequencer.
module multiboot_icap_seq #(
   parameter logic [7:0]  REG_COREADDR = 8'hFC,
   parameter logic [7:0]  REG_COREBOOT = 8'hFD,
   parameter logic [7:0]  REG_GOLDADDR = 8'hF7,
   parameter logic [23:0] DEFAULT_ADDR = 24'h058000,
   parameter logic [23:0] GOLDEN_ADDR  = 24'h000000,
   parameter logic [7:0]  READ_OPCODE  = 8'h6B,
   parameter int unsigned ICAP_DIV     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  zxuno_addr,
   input  logic        regaddr_changed,
   input  logic        zxuno_regrd,
   input  logic        zxuno_regwr,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   output logic        oe_n,
   output logic        icap_clk,
   output logic        icap_ce_n,
   output logic        icap_we_n,
   output logic [15:0] icap_i,
   output logic        busy
);

   localparam int unsigned DIV_W  = 8;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned PTR_W  = 2;
   localparam int unsigned DRN_W  = 2;
   localparam int unsigned ADDR_W = 24;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned NREG   = 3;

   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN, ST_DRAIN} state_t;

   function automatic logic [7:0] f_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = b[7-k];
      return r;
   endfunction

   function automatic logic [WORD_W-1:0] f_word(input logic [IDX_W-1:0] idx,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] g);
      logic [WORD_W-1:0] w;
      case (idx)
         4'd0:    w = 16'hFFFF;
         4'd1:    w = 16'hAA99;
         4'd2:    w = 16'h5566;
         4'd3:    w = 16'h3261;
         4'd4:    w = a[15:0];
         4'd5:    w = 16'h3281;
         4'd6:    w = {READ_OPCODE, a[23:16]};
         4'd7:    w = 16'h32A1;
         4'd8:    w = g[15:0];
         4'd9:    w = 16'h32C1;
         4'd10:   w = {READ_OPCODE, g[23:16]};
         4'd11:   w = 16'h3301;
         4'd12:   w = 16'h3100;
         4'd13:   w = 16'h30A1;
         4'd14:   w = 16'h000E;
         default: w = 16'h2000;
      endcase
      return {f_rev8(w[15:8]), f_rev8(w[7:0])};
   endfunction

   function automatic logic [7:0] f_byte(input logic [ADDR_W-1:0] v, input logic [PTR_W-1:0] p);
      case (p)
         2'd0:    return v[23:16];
         2'd1:    return v[15:8];
         default: return v[7:0];
      endcase
   endfunction

   // register bus decode and edge detection (bit0 core, bit1 boot, bit2 gold)
   logic [NREG-1:0] w_sel, w_wr_rise, w_rd_rise;
   logic [NREG-1:0] r_wrf, r_rdf;
   logic            w_rd_act, w_boot_req;
   logic [7:0]      w_rd_byte, r_dout_lat;
   logic [ADDR_W-1:0] r_addr, r_gold, r_snap_a, r_snap_g;
   logic [PTR_W-1:0]  r_ptr_core, r_ptr_gold;

   assign w_sel      = {zxuno_addr == REG_GOLDADDR, zxuno_addr == REG_COREBOOT, zxuno_addr == REG_COREADDR};
   assign w_wr_rise  = w_sel & {NREG{zxuno_regwr}} & ~r_wrf & {NREG{~regaddr_changed}};
   assign w_rd_rise  = w_sel & {NREG{zxuno_regrd}} & ~r_rdf;
   assign w_rd_act   = zxuno_regrd & (|w_sel);
   assign w_boot_req = w_wr_rise[1] & din[0];

   state_t r_state, w_state_nxt;
   logic   r_busy, r_done;

   // byte presented on a read rising edge
   always_comb begin
      w_rd_byte = 8'hFF;
      if (w_sel[0])      w_rd_byte = f_byte(r_addr, r_ptr_core);
      else if (w_sel[2]) w_rd_byte = f_byte(r_gold, r_ptr_gold);
      else if (w_sel[1]) w_rd_byte = {6'b0, r_done, r_busy};
   end

   assign dout = w_rd_act ? ((|w_rd_rise) ? w_rd_byte : r_dout_lat) : 8'hFF;
   assign oe_n = ~w_rd_act;

   // CPU-visible registers, read pointers and output latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrf      <= '0;
         r_rdf      <= '0;
         r_addr     <= DEFAULT_ADDR;
         r_gold     <= GOLDEN_ADDR;
         r_ptr_core <= '0;
         r_ptr_gold <= '0;
         r_dout_lat <= 8'hFF;
      end else begin
         r_wrf <= w_sel & {NREG{zxuno_regwr}};
         r_rdf <= w_sel & {NREG{zxuno_regrd}};
         if (w_wr_rise[0]) r_addr <= {r_addr[15:0], din};
         if (w_wr_rise[2]) r_gold <= {r_gold[15:0], din};
         if (regaddr_changed && w_sel[0])  r_ptr_core <= '0;
         else if (w_rd_rise[0])             r_ptr_core <= (r_ptr_core == 2'd2) ? 2'd0 : r_ptr_core + 2'd1;
         if (regaddr_changed && w_sel[2])  r_ptr_gold <= '0;
         else if (w_rd_rise[2])             r_ptr_gold <= (r_ptr_gold == 2'd2) ? 2'd0 : r_ptr_gold + 2'd1;
         if (|w_rd_rise) r_dout_lat <= w_rd_byte;
      end
   end

   // free-running ICAP clock divider
   logic [DIV_W-1:0] r_div_cnt;
   logic             r_icap_clk, w_wrap, w_fall;
   assign w_wrap = (r_div_cnt == DIV_W'(ICAP_DIV - 1));
   assign w_fall = w_wrap & r_icap_clk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt  <= '0;
         r_icap_clk <= 1'b0;
      end else if (w_wrap) begin
         r_div_cnt  <= '0;
         r_icap_clk <= ~r_icap_clk;
      end else begin
         r_div_cnt  <= r_div_cnt + 8'd1;
      end
   end

   // sequencer next-state and output values
   logic [IDX_W-1:0]  r_idx, w_idx_nxt;
   logic [DRN_W-1:0]  r_drain, w_drain_nxt;
   logic              r_ce_n, r_we_n, w_ce_nxt, w_we_nxt, w_done_nxt, w_snap_ld;
   logic [WORD_W-1:0] r_icap_i, w_i_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_drain_nxt = r_drain;
      w_ce_nxt    = r_ce_n;
      w_we_nxt    = r_we_n;
      w_i_nxt     = r_icap_i;
      w_done_nxt  = r_done;
      w_snap_ld   = 1'b0;
      case (r_state)
         ST_IDLE: if (w_boot_req) begin
            w_state_nxt = ST_ARM;
            w_snap_ld   = 1'b1;
            w_idx_nxt   = '0;
         end
         ST_ARM: if (w_fall) begin
            w_state_nxt = ST_RUN;
            w_ce_nxt    = 1'b1;
            w_we_nxt    = 1'b1;
            w_i_nxt     = f_word(4'd0, r_snap_a, r_snap_g);
            w_idx_nxt   = 4'd1;
         end
         ST_RUN: if (w_fall) begin
            w_ce_nxt  = 1'b0;
            w_we_nxt  = 1'b0;
            w_i_nxt   = f_word(r_idx, r_snap_a, r_snap_g);
            w_idx_nxt = r_idx + 4'd1;
            if (r_idx == 4'd15) begin
               w_state_nxt = ST_DRAIN;
               w_drain_nxt = '0;
            end
         end
         ST_DRAIN: if (w_fall) begin
            w_ce_nxt = 1'b1;
            w_we_nxt = 1'b1;
            w_i_nxt  = 16'hFFFF;
            if (r_drain == 2'd2) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_drain_nxt = r_drain + 2'd1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // sequencer state and registered ICAP outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_drain  <= '0;
         r_ce_n   <= 1'b1;
         r_we_n   <= 1'b1;
         r_icap_i <= 16'hFFFF;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_snap_a <= DEFAULT_ADDR;
         r_snap_g <= GOLDEN_ADDR;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_drain  <= w_drain_nxt;
         r_ce_n   <= w_ce_nxt;
         r_we_n   <= w_we_nxt;
         r_icap_i <= w_i_nxt;
         r_busy   <= (w_state_nxt != ST_IDLE);
         r_done   <= w_done_nxt;
         if (w_snap_ld) begin
            r_snap_a <= r_addr;
            r_snap_g <= r_gold;
         end
      end
   end

   assign icap_clk  = r_icap_clk;
   assign icap_ce_n = r_ce_n;
   assign icap_we_n = r_we_n;
   assign icap_i    = r_icap_i;
   assign busy      = r_busy;

endmodule

// File: tb/tb_multiboot_icap_seq.sv
// Self-checking bench for multiboot_icap_seq: register bus vectors plus ICAP stream and timing checks.
module tb_multiboot_icap_seq;

   localparam int OP_SEL = 0;
   localparam int OP_WR  = 1;
   localparam int OP_RD  = 2;

   typedef struct {
      int         op;
      logic [7:0] addr;
      logic [7:0] data;
      int         hold;
      logic [7:0] exp;
      logic       exp_oe;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] zxuno_addr = 8'h00;
   logic       regaddr_changed = 1'b0;
   logic       regrd = 1'b0;
   logic       regwr = 1'b0;
   logic [7:0] din = 8'h00;

   logic [7:0]  dout_a    [3];
   logic        oe_n_a    [3];
   logic        icap_clk_a[3];
   logic        icap_ce_a [3];
   logic        icap_we_a [3];
   logic [15:0] icap_i_a  [3];
   logic        busy_a    [3];

   int total = 0;
   int bad   = 0;

   // monitor state
   logic        p_clk[3], p_ce[3], p_we[3];
   logic [15:0] p_i[3];
   logic        p_rst = 1'b0;
   logic        seen[3];
   int          per[3];
   logic [15:0] cap[64];
   int          cap_n = 0;

   initial forever #5 clk = ~clk;

   multiboot_icap_seq #(.ICAP_DIV(2)) u_div2 (
      .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr), .regaddr_changed(regaddr_changed),
      .zxuno_regrd(regrd), .zxuno_regwr(regwr), .din(din), .dout(dout_a[0]), .oe_n(oe_n_a[0]),
      .icap_clk(icap_clk_a[0]), .icap_ce_n(icap_ce_a[0]), .icap_we_n(icap_we_a[0]),
      .icap_i(icap_i_a[0]), .busy(busy_a[0]));

   multiboot_icap_seq #(.ICAP_DIV(1)) u_div1 (
      .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr), .regaddr_changed(regaddr_changed),
      .zxuno_regrd(regrd), .zxuno_regwr(regwr), .din(din), .dout(dout_a[1]), .oe_n(oe_n_a[1]),
      .icap_clk(icap_clk_a[1]), .icap_ce_n(icap_ce_a[1]), .icap_we_n(icap_we_a[1]),
      .icap_i(icap_i_a[1]), .busy(busy_a[1]));

   multiboot_icap_seq #(.ICAP_DIV(5)) u_div5 (
      .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr), .regaddr_changed(regaddr_changed),
      .zxuno_regrd(regrd), .zxuno_regwr(regwr), .din(din), .dout(dout_a[2]), .oe_n(oe_n_a[2]),
      .icap_clk(icap_clk_a[2]), .icap_ce_n(icap_ce_a[2]), .icap_we_n(icap_we_a[2]),
      .icap_i(icap_i_a[2]), .busy(busy_a[2]));

   function automatic int div_of(input int k);
      case (k)
         0:       return 2;
         1:       return 1;
         default: return 5;
      endcase
   endfunction

   function automatic logic [15:0] brev(input logic [15:0] w);
      logic [15:0] r;
      for (int k = 0; k < 8; k++) begin
         r[k]     = w[7-k];
         r[8+k]   = w[15-k];
      end
      return r;
   endfunction

   // IPROG word as the ICAP should see it (before pin bit reversal)
   function automatic logic [15:0] exp_word(input int idx, input logic [23:0] a, input logic [23:0] g);
      logic [15:0] tab [16];
      tab = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, a[15:0], 16'h3281, {8'h6B, a[23:16]}, 16'h32A1,
              g[15:0], 16'h32C1, {8'h6B, g[23:16]}, 16'h3301, 16'h3100, 16'h30A1, 16'h000E, 16'h2000};
      return tab[idx];
   endfunction

   function automatic vec_t mk(input int op, input logic [7:0] addr, input logic [7:0] data,
                               input int hold, input logic [7:0] exp, input logic exp_oe);
      vec_t v;
      v.op = op; v.addr = addr; v.data = data; v.hold = hold; v.exp = exp; v.exp_oe = exp_oe;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic sel_reg(input logic [7:0] a);
      @(posedge clk); #1;
      zxuno_addr = a; regaddr_changed = 1'b1;
      @(posedge clk); #1;
      regaddr_changed = 1'b0;
   endtask

   task automatic wr_reg(input logic [7:0] d, input int hold);
      @(posedge clk); #1;
      din = d; regwr = 1'b1;
      repeat (hold) @(posedge clk);
      #1 regwr = 1'b0;
   endtask

   task automatic rd_reg(input string name, input logic [7:0] exp, input logic exp_oe);
      @(posedge clk); #1;
      regrd = 1'b1;
      @(negedge clk);
      chk({name, ".dout"}, 32'(dout_a[0]), 32'(exp));
      chk({name, ".oe_n"}, 32'(oe_n_a[0]), 32'(exp_oe));
      @(posedge clk); #1;
      regrd = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int c = 0; c < 1000 && busy_a[0]; c++) @(negedge clk);
      chk({name, ".busy_timeout"}, 32'(busy_a[0]), 32'd0);
   endtask

   // alignment/period checks for every instance plus word capture on instance 0
   task automatic mon();
      for (int k = 0; k < 3; k++) begin
         if (!rst_n || !p_rst) begin
            seen[k] = 1'b0;
            per[k]  = 0;
         end else begin
            logic fell;
            fell = p_clk[k] && !icap_clk_a[k];
            per[k]++;
            if (icap_i_a[k] != p_i[k] || icap_ce_a[k] != p_ce[k] || icap_we_a[k] != p_we[k])
               chk($sformatf("align_div%0d", div_of(k)), 32'(fell), 32'd1);
            if (fell) begin
               if (seen[k]) chk($sformatf("period_div%0d", div_of(k)), 32'(per[k]), 32'(2 * div_of(k)));
               seen[k] = 1'b1;
               per[k]  = 0;
            end
            if (k == 0 && !p_clk[k] && icap_clk_a[k] && !icap_ce_a[k] && cap_n < 64) begin
               cap[cap_n] = icap_i_a[k];
               cap_n++;
            end
         end
         p_clk[k] = icap_clk_a[k];
         p_i[k]   = icap_i_a[k];
         p_ce[k]  = icap_ce_a[k];
         p_we[k]  = icap_we_a[k];
      end
      p_rst = rst_n;
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            mon();
         end
         begin : main_seq
            vec_t tbl[$];
            int   base;

            // reset values while held in reset
            repeat (2) @(negedge clk);
            chk("rst.ce_n", 32'(icap_ce_a[0]), 32'd1);
            chk("rst.we_n", 32'(icap_we_a[0]), 32'd1);
            chk("rst.icap_i", 32'(icap_i_a[0]), 32'hFFFF);
            chk("rst.icap_clk", 32'(icap_clk_a[0]), 32'd0);
            chk("rst.busy", 32'(busy_a[0]), 32'd0);
            rst_n = 1'b1;

            // register bus vectors: reset readback, unselected read, byte writes, held write
            tbl.push_back(mk(OP_SEL, 8'hFC, 8'h00, 0, 8'h00, 1'b1));
            tbl.push_back(mk(OP_RD,  8'hFC, 8'h00, 0, 8'h05, 1'b0));
            tbl.push_back(mk(OP_RD,  8'hFC, 8'h00, 0, 8'h80, 1'b0));
            tbl.push_back(mk(OP_RD,  8'hFC, 8'h00, 0, 8'h00, 1'b0));
            tbl.push_back(mk(OP_RD,  8'hFC, 8'h00, 0, 8'h05, 1'b0));
            tbl.push_back(mk(OP_SEL, 8'hF7, 8'h00, 0, 8'h00, 1'b1));
            tbl.push_back(mk(OP_RD,  8'hF7, 8'h00, 0, 8'h00, 1'b0));
            tbl.push_back(mk(OP_RD,  8'hF7, 8'h00, 0, 8'h00, 1'b0));
            tbl.push_back(mk(OP_RD,  8'hF7, 8'h00, 0, 8'h00, 1'b0));
            tbl.push_back(mk(OP_SEL, 8'hFD, 8'h00, 0, 8'h00, 1'b1));
            tbl.push_back(mk(OP_RD,  8'hFD, 8'h00, 0, 8'h00, 1'b0));
            tbl.push_back(mk(OP_SEL, 8'h40, 8'h00, 0, 8'h00, 1'b1));
            tbl.push_back(mk(OP_RD,  8'h40, 8'h00, 0, 8'hFF, 1'b1));
            tbl.push_back(mk(OP_SEL, 8'hFC, 8'h00, 0, 8'h00, 1'b1));
            tbl.push_back(mk(OP_WR,  8'hFC, 8'h12, 1, 8'h00, 1'b1));
            tbl.push_back(mk(OP_WR,  8'hFC, 8'h34, 5, 8'h00, 1'b1));
            tbl.push_back(mk(OP_WR,  8'hFC, 8'h56, 1, 8'h00, 1'b1));
            tbl.push_back(mk(OP_SEL, 8'hFC, 8'h00, 0, 8'h00, 1'b1));
            tbl.push_back(mk(OP_RD,  8'hFC, 8'h00, 0, 8'h12, 1'b0));
            tbl.push_back(mk(OP_RD,  8'hFC, 8'h00, 0, 8'h34, 1'b0));
            tbl.push_back(mk(OP_RD,  8'hFC, 8'h00, 0, 8'h56, 1'b0));
            foreach (tbl[i]) begin
               case (tbl[i].op)
                  OP_SEL:  sel_reg(tbl[i].addr);
                  OP_WR:   wr_reg(tbl[i].data, tbl[i].hold);
                  default: rd_reg($sformatf("vec%0d", i), tbl[i].exp, tbl[i].exp_oe);
               endcase
            end

            // reboot with A=123456; writes while busy must not disturb the stream
            base = cap_n;
            sel_reg(8'hFD);
            wr_reg(8'h01, 1);
            @(negedge clk);
            chk("boot.busy", 32'(busy_a[0]), 32'd1);
            rd_reg("boot.status_busy", 8'h01, 1'b0);
            wr_reg(8'h01, 1);
            sel_reg(8'hFC);
            wr_reg(8'hAA, 1);
            wait_idle("boot");
            chk("boot.words", 32'(cap_n - base), 32'd15);
            for (int w = 1; w <= 15; w++)
               chk($sformatf("boot.word%0d", w), 32'(cap[base + w - 1]),
                   32'(brev(exp_word(w, 24'h123456, 24'h000000))));
            repeat (40) @(negedge clk);
            chk("boot.no_second", 32'(cap_n - base), 32'd15);
            chk("boot.still_idle", 32'(busy_a[0]), 32'd0);
            chk("boot.ce_idle", 32'(icap_ce_a[0]), 32'd1);
            sel_reg(8'hFD);
            rd_reg("boot.status_done", 8'h02, 1'b0);
            sel_reg(8'hFC);
            rd_reg("busywr.b0", 8'h34, 1'b0);
            rd_reg("busywr.b1", 8'h56, 1'b0);
            rd_reg("busywr.b2", 8'hAA, 1'b0);

            // second reboot with A=3456AA, aborted by reset after word 7
            base = cap_n;
            sel_reg(8'hFD);
            wr_reg(8'h01, 1);
            for (int c = 0; c < 1000 && (cap_n - base) < 7; c++) @(posedge clk);
            chk("abort.reached7", 32'(cap_n - base), 32'd7);
            chk("abort.word4", 32'(cap[base + 3]), 32'(brev(16'h56AA)));
            chk("abort.word6", 32'(cap[base + 5]), 32'(brev(16'h6B34)));
            #1 rst_n = 1'b0;
            #1;
            chk("abort.ce_n", 32'(icap_ce_a[0]), 32'd1);
            chk("abort.we_n", 32'(icap_we_a[0]), 32'd1);
            chk("abort.icap_i", 32'(icap_i_a[0]), 32'hFFFF);
            chk("abort.busy", 32'(busy_a[0]), 32'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (20) @(negedge clk);
            chk("abort.no_more_words", 32'(cap_n - base), 32'd7);
            sel_reg(8'hFD);
            rd_reg("abort.status", 8'h00, 1'b0);
            sel_reg(8'hFC);
            rd_reg("abort.a0", 8'h05, 1'b0);
            rd_reg("abort.a1", 8'h80, 1'b0);
            rd_reg("abort.a2", 8'h00, 1'b0);

            // COREBOOT write coinciding with regaddr_changed is dropped
            @(posedge clk); #1;
            zxuno_addr = 8'hFD; regaddr_changed = 1'b1; din = 8'h01; regwr = 1'b1;
            @(posedge clk); #1;
            regaddr_changed = 1'b0; regwr = 1'b0;
            repeat (4) @(negedge clk);
            chk("collide.busy", 32'(busy_a[0]), 32'd0);
            wr_reg(8'h01, 1);
            @(negedge clk);
            chk("collide.retry_busy", 32'(busy_a[0]), 32'd1);
            wait_idle("retry");
         end
      join_any
      disable fork;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
